btb_update_ctrl: RTL and testbench
==================================

Name: btb_update_ctrl

Overview:
- Sequences all writes into the 64-entry direct-mapped BTB storage. Resolved-branch outcomes from the EX-stage judge enter a small update FIFO, and the block drains them one per cycle onto the single BTB write port.
- Also performs the full-table invalidate sweep after reset and on a flush command, and gates IF-stage lookups while the table contents are not trustworthy.
- Sits between the EX branch judge (producer) and the BTB array (consumer). It asserts a stall request toward the hazard logic when its FIFO nears full.

Parameters:
IDX_W, 6, BTB index width; the table has 2^IDX_W entries; index = pc[IDX_W+1:2]
TAG_W, 24, tag width; tag = pc[31:IDX_W+2]; must equal 30-IDX_W
FIFO_DEPTH, 4, update FIFO entries; power of two, at least 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
upd_valid  in  1  EX-stage branch outcome event this cycle
upd_kind  in  2  2'b10 = taken but predicted not-taken (install); 2'b01 = not-taken but predicted taken (invalidate); 00/11 ignored
upd_pc  in  32  PC of the branch in EX
upd_target  in  32  resolved branch target
flush_all  in  1  one-cycle request to invalidate the whole BTB
btb_we  out  1  BTB write strobe; the array samples at the next rising edge
btb_idx  out  IDX_W  write index
btb_tag  out  TAG_W  write tag
btb_target  out  32  write target
btb_vld  out  1  valid bit to write
lookup_en  out  1  when 1, IF may use BTB hits; 0 forces predict-not-taken
busy  out  1  high in INIT or SWEEP
stall_req  out  1  FIFO count >= FIFO_DEPTH-1
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
ovf_err  out  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (rst=0, asynchronous):
  - state=INIT, sweep_ptr=0, FIFO empty, ovf_err=0.
  - Outputs: btb_we=1, btb_idx=0, btb_vld=0, btb_tag=0, btb_target=0, lookup_en=0, busy=1, stall_req=0, fifo_count=0.
- Write-port outputs are combinational from the state, sweep_ptr and FIFO head. The FIFO and the pointer are registered.
- Enqueue:
  - upd_valid=1 with upd_kind in {10, 01} pushes {kind, idx, tag, target} at the clock edge, in any state.
  - Other kinds are discarded and have no effect.
- States:
  - INIT / SWEEP: btb_we=1, btb_idx=sweep_ptr, btb_vld=0, tag=0, target=0, lookup_en=0, busy=1. sweep_ptr increments every cycle. After the cycle with sweep_ptr=2^IDX_W-1, the next state is IDLE and sweep_ptr returns to 0. The full sweep takes exactly 2^IDX_W cycles. The FIFO is not popped during a sweep.
  - IDLE: lookup_en=1, busy=0.
    - FIFO non-empty: btb_we=1, driven from the head, and the head pops at the edge.
    - Head kind 10: btb_vld=1 with the stored tag and target.
    - Head kind 01: btb_vld=0, tag/target as stored.
    - FIFO empty: btb_we=0; other write outputs hold 0.
- flush_all (any state):
  - Next state is SWEEP with sweep_ptr=0. All FIFO contents are cleared at that edge.
  - An update event in the same cycle is dropped (flush wins).
  - flush_all during an ongoing sweep restarts it at index 0.
- Events arriving during a sweep, after the flush edge, are retained and written once in IDLE.
- FIFO boundaries:
  - Push and pop in the same cycle: count is unchanged, including when full.
  - Push when full and no pop: the event is dropped and ovf_err is set. ovf_err clears only on reset.
  - Pointers wrap modulo FIFO_DEPTH. Write order is strictly FIFO; there is no coalescing of same-index events and no bypass to IF lookups.
- Reset released mid-operation restarts INIT from index 0.

Decomposition:
- Shared package btb_pkg holds:
  - IDX_W, TAG_W
  - upd_kind encodings KIND_INSTALL=2'b10 and KIND_INVAL=2'b01, shared with the EX judge
  - state enum {INIT, IDLE, SWEEP}
  - pc-to-index/tag split helpers
- One sub-module, btb_upd_fifo: a parameterised synchronous FIFO with push, pop, clear, count and full/empty. The FSM and sweep counter stay in the top.

Test Plan:
- Reset release -> btb_we=1 for exactly 64 cycles with idx 0..63, btb_vld=0. Then lookup_en=1, busy=0, btb_we=0.
- In IDLE, upd_valid with kind=10, pc=0x0000_0104, target=0x0000_0200 -> next cycle btb_we=1, idx=1, tag=0x000001, target=0x200, btb_vld=1. FIFO returns to 0.
- Four back-to-back events during INIT -> fifo_count reaches 4 and stall_req is high at count 3. After the sweep, four writes occur in order on consecutive cycles.
- FIFO full with no pop (during a sweep) plus a fifth event -> event dropped, ovf_err=1, count stays 4.
- flush_all with 2 events queued and one arriving the same cycle -> FIFO cleared and a 64-cycle sweep runs. No queued write ever appears.
- flush_all at sweep index 30 -> sweep restarts at idx 0 and runs 64 further cycles.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared BTB definitions: table geometry, update-kind encodings, controller states
// and helpers that split a PC into BTB index and tag.
package btb_pkg;

    localparam int IDX_W = 6;
    localparam int TAG_W = 24;

    localparam logic [1:0] KIND_INSTALL = 2'b10;
    localparam logic [1:0] KIND_INVAL   = 2'b01;

    typedef enum logic [1:0] {
        INIT  = 2'b00,
        IDLE  = 2'b01,
        SWEEP = 2'b10
    } btb_state_e;

    typedef struct packed {
        logic [1:0]       kind;
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
    } upd_entry_t;

    function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
        return pc[31:IDX_W+2];
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO for pending BTB writes; clear has priority over push/pop,
// and a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module btb_upd_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_MAX);
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: drains queued branch-resolution updates onto the single BTB
// write port and runs the full-table invalidate sweep after reset or on flush.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          upd_valid,
    input  logic [1:0]                    upd_kind,
    input  logic [31:0]                   upd_pc,
    input  logic [31:0]                   upd_target,
    input  logic                          flush_all,
    output logic                          btb_we,
    output logic [IDX_W-1:0]              btb_idx,
    output logic [TAG_W-1:0]              btb_tag,
    output logic [31:0]                   btb_target,
    output logic                          btb_vld,
    output logic                          lookup_en,
    output logic                          busy,
    output logic                          stall_req,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          ovf_err
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] SWEEP_LAST = '1;
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [CNT_W-1:0] STALL_LVL  = CNT_W'(FIFO_DEPTH - 1);

    btb_state_e       state_r;
    btb_state_e       state_nxt_s;
    logic [IDX_W-1:0] sweep_ptr_r;
    logic [IDX_W-1:0] sweep_ptr_nxt_s;
    logic             ovf_err_r;
    logic             enq_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    upd_entry_t       enq_entry_s;
    upd_entry_t       head_s;

    // A flush in the same cycle wins over any arriving update.
    assign enq_s = upd_valid && !flush_all &&
                   ((upd_kind == KIND_INSTALL) || (upd_kind == KIND_INVAL));
    assign pop_s = (state_r == IDLE) && !fifo_empty_s;

    assign enq_entry_s.kind   = upd_kind;
    assign enq_entry_s.idx    = pc_idx(upd_pc);
    assign enq_entry_s.tag    = pc_tag(upd_pc);
    assign enq_entry_s.target = upd_target;

    btb_upd_fifo #(
        .WIDTH ($bits(upd_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .clr   (flush_all),
        .push  (enq_s),
        .pop   (pop_s),
        .din   (enq_entry_s),
        .dout  (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // State, sweep pointer and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= INIT;
            sweep_ptr_r <= '0;
            ovf_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            sweep_ptr_r <= sweep_ptr_nxt_s;
            ovf_err_r   <= ovf_err_r || (enq_s && fifo_full_s && !pop_s);
        end
    end

    // Next-state and sweep pointer sequencing.
    always_comb begin
        state_nxt_s     = state_r;
        sweep_ptr_nxt_s = sweep_ptr_r;
        if (flush_all) begin
            state_nxt_s     = SWEEP;
            sweep_ptr_nxt_s = '0;
        end else begin
            case (state_r)
                INIT, SWEEP: begin
                    if (sweep_ptr_r == SWEEP_LAST) begin
                        state_nxt_s     = IDLE;
                        sweep_ptr_nxt_s = '0;
                    end else begin
                        sweep_ptr_nxt_s = sweep_ptr_r + IDX_ONE;
                    end
                end
                IDLE: begin
                    state_nxt_s     = IDLE;
                    sweep_ptr_nxt_s = '0;
                end
                default: begin
                    state_nxt_s     = INIT;
                    sweep_ptr_nxt_s = '0;
                end
            endcase
        end
    end

    // Write-port and lookup gating decode from state, sweep pointer and FIFO head.
    always_comb begin
        btb_we     = 1'b0;
        btb_idx    = '0;
        btb_tag    = '0;
        btb_target = 32'h0000_0000;
        btb_vld    = 1'b0;
        lookup_en  = 1'b0;
        busy       = 1'b1;
        case (state_r)
            INIT, SWEEP: begin
                btb_we  = 1'b1;
                btb_idx = sweep_ptr_r;
            end
            IDLE: begin
                lookup_en = 1'b1;
                busy      = 1'b0;
                if (!fifo_empty_s) begin
                    btb_we     = 1'b1;
                    btb_idx    = head_s.idx;
                    btb_tag    = head_s.tag;
                    btb_target = head_s.target;
                    btb_vld    = (head_s.kind == KIND_INSTALL);
                end else begin
                    btb_we = 1'b0;
                end
            end
            default: begin
                btb_we = 1'b0;
            end
        endcase
    end

    assign stall_req  = (fifo_count_s >= STALL_LVL);
    assign fifo_count = fifo_count_s;
    assign ovf_err    = ovf_err_r;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: stimulus queues expected BTB writes,
// a negedge monitor pops and compares every strobe on the write port.
module tb_btb_update_ctrl;

    typedef struct packed {
        logic [5:0]  idx;
        logic [23:0] tag;
        logic [31:0] target;
        logic        vld;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        upd_valid;
    logic [1:0]  upd_kind;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        flush_all;
    logic        btb_we;
    logic [5:0]  btb_idx;
    logic [23:0] btb_tag;
    logic [31:0] btb_target;
    logic        btb_vld;
    logic        lookup_en;
    logic        busy;
    logic        stall_req;
    logic [2:0]  fifo_count;
    logic        ovf_err;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    wr_t mon_exp;
    wr_t mon_act;

    btb_update_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .upd_valid  (upd_valid),
        .upd_kind   (upd_kind),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .flush_all  (flush_all),
        .btb_we     (btb_we),
        .btb_idx    (btb_idx),
        .btb_tag    (btb_tag),
        .btb_target (btb_target),
        .btb_vld    (btb_vld),
        .lookup_en  (lookup_en),
        .busy       (busy),
        .stall_req  (stall_req),
        .fifo_count (fifo_count),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every write strobe out of reset must match the scoreboard head.
    always @(negedge clk) begin
        if (rst && btb_we) begin
            checks++;
            mon_act = '{idx: btb_idx, tag: btb_tag, target: btb_target, vld: btb_vld};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual idx=%0d tag=%h tgt=%h vld=%0d required no write",
                         btb_idx, btb_tag, btb_target, btb_vld);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL btb_write actual idx=%0d tag=%h tgt=%h vld=%0d required idx=%0d tag=%h tgt=%h vld=%0d",
                             mon_act.idx, mon_act.tag, mon_act.target, mon_act.vld,
                             mon_exp.idx, mon_exp.tag, mon_exp.target, mon_exp.vld);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_wr(input logic [5:0] idx, input logic [23:0] tag,
                          input logic [31:0] tgt, input logic vld);
        exp_q.push_back('{idx: idx, tag: tag, target: tgt, vld: vld});
    endtask

    task automatic exp_sweep(input int last);
        for (int i = 0; i <= last; i++) begin
            exp_wr(6'(i), 24'h000000, 32'h0000_0000, 1'b0);
        end
    endtask

    task automatic ev(input logic [1:0] kind, input logic [31:0] pc, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_kind   = kind;
        upd_pc     = pc;
        upd_target = tgt;
    endtask

    task automatic ev_clear();
        upd_valid  = 1'b0;
        upd_kind   = 2'b00;
        upd_pc     = 32'h0000_0000;
        upd_target = 32'h0000_0000;
    endtask

    initial begin
        rst       = 1'b0;
        flush_all = 1'b0;
        ev_clear();
        repeat (3) cyc();

        chk("rst_we", btb_we, 1'b1);
        chk("rst_idx", btb_idx, 6'd0);
        chk("rst_vld", btb_vld, 1'b0);
        chk("rst_tag", btb_tag, 24'h0);
        chk("rst_target", btb_target, 32'h0);
        chk("rst_lookup_en", lookup_en, 1'b0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_stall", stall_req, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_ovf", ovf_err, 1'b0);

        // Initial sweep: 64 invalidating writes, then idle.
        rst = 1'b1;
        exp_sweep(63);
        repeat (64) cyc();
        chk("init_done_busy", busy, 1'b0);
        chk("init_done_lookup", lookup_en, 1'b1);
        chk("init_done_we", btb_we, 1'b0);
        chk("init_sweep_all_seen", exp_q.size(), 0);

        // Install in IDLE.
        ev(2'b10, 32'h0000_0104, 32'h0000_0200);
        exp_wr(6'd1, 24'h000001, 32'h0000_0200, 1'b1);
        cyc();
        ev_clear();
        chk("install_count1", fifo_count, 3'd1);
        cyc();
        chk("install_count0", fifo_count, 3'd0);
        chk("install_we_off", btb_we, 1'b0);

        // Invalidate at the top index / max tag.
        ev(2'b01, 32'hFFFF_FFFC, 32'h1234_5678);
        exp_wr(6'd63, 24'hFFFFFF, 32'h1234_5678, 1'b0);
        cyc();
        ev_clear();
        cyc();
        chk("inval_count0", fifo_count, 3'd0);

        // Ignored kinds.
        ev(2'b00, 32'h0000_0400, 32'h0000_0010);
        cyc();
        ev(2'b11, 32'h0000_0800, 32'h0000_0020);
        cyc();
        ev_clear();
        chk("ignored_count", fifo_count, 3'd0);
        chk("ignored_we", btb_we, 1'b0);

        // Reset mid-operation, then fill the FIFO during INIT and overflow it.
        rst = 1'b0;
        #1;
        chk("rerst_lookup", lookup_en, 1'b0);
        chk("rerst_ovf", ovf_err, 1'b0);
        cyc();
        rst = 1'b1;
        exp_sweep(63);
        ev(2'b10, 32'h0000_1008, 32'h0000_3000);
        exp_wr(6'd2, 24'h000010, 32'h0000_3000, 1'b1);
        cyc();
        chk("fill_count1", fifo_count, 3'd1);
        chk("fill_stall1", stall_req, 1'b0);
        ev(2'b01, 32'h0000_20FC, 32'h0000_4000);
        exp_wr(6'd63, 24'h000020, 32'h0000_4000, 1'b0);
        cyc();
        chk("fill_count2", fifo_count, 3'd2);
        chk("fill_stall2", stall_req, 1'b0);
        ev(2'b10, 32'hABCD_EF10, 32'h8000_0004);
        exp_wr(6'd4, 24'hABCDEF, 32'h8000_0004, 1'b1);
        cyc();
        chk("fill_count3", fifo_count, 3'd3);
        chk("fill_stall3", stall_req, 1'b1);
        ev(2'b10, 32'h0000_0000, 32'hFFFF_FFFF);
        exp_wr(6'd0, 24'h000000, 32'hFFFF_FFFF, 1'b1);
        cyc();
        chk("fill_count4", fifo_count, 3'd4);
        chk("fill_ovf_before", ovf_err, 1'b0);
        ev(2'b10, 32'h0000_0044, 32'h0000_5000);
        cyc();
        ev_clear();
        chk("ovf_count4", fifo_count, 3'd4);
        chk("ovf_set", ovf_err, 1'b1);
        repeat (59) cyc();
        chk("drain_start_busy", busy, 1'b0);
        chk("drain_start_count", fifo_count, 3'd4);
        repeat (4) cyc();
        chk("drain_done_count", fifo_count, 3'd0);
        chk("ovf_sticky", ovf_err, 1'b1);

        // Flush from IDLE, queue two events, then flush at index 30 with a third arriving.
        flush_all = 1'b1;
        cyc();
        flush_all = 1'b0;
        chk("flush_busy", busy, 1'b1);
        exp_sweep(30);
        ev(2'b10, 32'h0000_0100, 32'h0000_0001);
        cyc();
        ev(2'b01, 32'h0000_0200, 32'h0000_0002);
        cyc();
        ev_clear();
        chk("flush_queued2", fifo_count, 3'd2);
        repeat (28) cyc();
        chk("flush_at_idx30", btb_idx, 6'd30);
        flush_all = 1'b1;
        ev(2'b10, 32'h0000_0300, 32'h0000_0003);
        cyc();
        flush_all = 1'b0;
        ev_clear();
        chk("reflush_count0", fifo_count, 3'd0);
        chk("reflush_idx0", btb_idx, 6'd0);
        exp_sweep(63);
        repeat (64) cyc();
        chk("reflush_done_busy", busy, 1'b0);
        chk("reflush_done_lookup", lookup_en, 1'b1);
        repeat (4) cyc();
        chk("final_we_off", btb_we, 1'b0);
        chk("final_all_writes_seen", exp_q.size(), 0);

        rst = 1'b0;
        #1;
        chk("final_rst_ovf_clear", ovf_err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
